// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants and types for the multicycle MIPS main control.
//   - state_t   : 4-bit FSM state encoding
//   - OP_*      : instruction opcodes (IR[31:26])
//   - ALUOP_*   : ALUOp encodings consumed by ALU_control
//   - SRCB_*, PCSRC_* : datapath mux select encodings
//   - ctrl_t    : packed control word produced by mc_ctrl_decode
//   - dispatch(): DECODE-state opcode dispatch (FETCH means illegal opcode)
// Optional feature macro: MC_CTRL_BNE_EN (bne takes the beq path to BRANCH).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  // Where DECODE goes for a given opcode; S_FETCH marks an unknown opcode.
  function automatic state_t dispatch(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:                                      nxt = S_EXEC;
      OP_LW, OP_SW:                                  nxt = S_MEMADR;
      OP_BEQ:                                        nxt = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
      OP_BNE:                                        nxt = S_BRANCH;
`endif
      OP_J:                                          nxt = S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:    nxt = S_IEXEC;
      default:                                       nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  // Logical immediates take a zero-extended operand.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state-to-control-word decode.
// Ports:
//   state     in  current FSM state
//   mem_ready in  memory access complete (only FETCH and MEMWR look at it)
//   op        in  live opcode, used in DECODE to flag unknown opcodes
//   op_q      in  opcode latched when leaving DECODE
//   ctrl      out full control word (unused fields are 0)
// Macro MC_CTRL_BNE_EN: when defined, BranchNe is raised in BRANCH for bne.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic [5:0] op,
  input  logic [5:0] op_q,
  output ctrl_t      ctrl
);

  // Moore control word per state; everything defaults to 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = (dispatch(op) == S_FETCH);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
`ifdef MC_CTRL_BNE_EN
        ctrl.branch_ne     = (op_q == OP_BNE);
`else
        ctrl.branch_ne     = 1'b0;
`endif
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ITYPE;
        ctrl.zero_ext  = is_zext_op(op_q);
      end
      S_IWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS CPU.
// Holds the state register, the latched opcode and the next-state logic;
// the per-state control word comes from mc_ctrl_decode.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   Op[5:0]      opcode IR[31:26], valid from DECODE onward
//   mem_ready    memory completed the current access
//   PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ZeroExt,
//   ALUOp[1:0], PCSource[1:0]  datapath controls
//   illegal_op   pulse in DECODE for an unknown opcode
//   instr_done   pulse in the last state of each instruction
// Macro MC_CTRL_BNE_EN: enables bne (000101) via the BRANCH state.
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ZeroExt,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic       instr_done
);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [5:0] op_q_r;
  ctrl_t      dec_s;
  ctrl_t      ctrl_s;

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) state_nxt_s = S_DECODE;
        else           state_nxt_s = S_FETCH;
      end
      S_DECODE: state_nxt_s = dispatch(Op);
      S_MEMADR: begin
        if (op_q_r == OP_SW) state_nxt_s = S_MEMWR;
        else                 state_nxt_s = S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ready) state_nxt_s = S_MEMWB;
        else           state_nxt_s = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready) state_nxt_s = S_FETCH;
        else           state_nxt_s = S_MEMWR;
      end
      S_EXEC:   state_nxt_s = S_RWB;
      S_IEXEC:  state_nxt_s = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_nxt_s = S_FETCH;
      default:  state_nxt_s = S_FETCH;
    endcase
  end

  // State register and opcode latch (opcode captured on the DECODE exit edge).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
      op_q_r  <= 6'b000000;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == S_DECODE) op_q_r <= Op;
      else                     op_q_r <= op_q_r;
    end
  end

  mc_ctrl_decode u_decode (
    .state     (state_r),
    .mem_ready (mem_ready),
    .op        (Op),
    .op_q      (op_q_r),
    .ctrl      (dec_s)
  );

  // Reset forces every strobe and select low in the very cycle it is seen,
  // so an abandoned memory wait drops its request immediately.
  always_comb begin
    if (!rst_n) ctrl_s = '0;
    else        ctrl_s = dec_s;
  end

  assign PCWrite     = ctrl_s.pc_write;
  assign PCWriteCond = ctrl_s.pc_write_cond;
  assign BranchNe    = ctrl_s.branch_ne;
  assign IorD        = ctrl_s.iord;
  assign MemRead     = ctrl_s.mem_read;
  assign MemWrite    = ctrl_s.mem_write;
  assign IRWrite     = ctrl_s.ir_write;
  assign MemtoReg    = ctrl_s.mem_to_reg;
  assign RegDst      = ctrl_s.reg_dst;
  assign RegWrite    = ctrl_s.reg_write;
  assign ALUSrcA     = ctrl_s.alu_src_a;
  assign ALUSrcB     = ctrl_s.alu_src_b;
  assign ZeroExt     = ctrl_s.zero_ext;
  assign ALUOp       = ctrl_s.alu_op;
  assign PCSource    = ctrl_s.pc_source;
  assign illegal_op  = ctrl_s.illegal_op;
  assign instr_done  = ctrl_s.instr_done;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: cycle-by-cycle vector table with a
// scoreboard queue, plus a reactive lw sequence with memory wait states.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ZeroExt, illegal_op, instr_done;
  logic [1:0] ALUSrcB, ALUOp, PCSource;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .instr_done(instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word: {PCWrite,PCWriteCond,BranchNe,IorD,MemRead,MemWrite,IRWrite,
  //   MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB[2],ZeroExt,ALUOp[2],PCSource[2],
  //   illegal_op,instr_done}
  logic [19:0] obs;
  assign obs = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ZeroExt, ALUOp,
                PCSource, illegal_op, instr_done};

  localparam logic [19:0] M_PCW   = 20'h1 << 19;
  localparam logic [19:0] M_PCWC  = 20'h1 << 18;
  localparam logic [19:0] M_BNE   = 20'h1 << 17;
  localparam logic [19:0] M_IORD  = 20'h1 << 16;
  localparam logic [19:0] M_MRD   = 20'h1 << 15;
  localparam logic [19:0] M_MWR   = 20'h1 << 14;
  localparam logic [19:0] M_IRW   = 20'h1 << 13;
  localparam logic [19:0] M_M2R   = 20'h1 << 12;
  localparam logic [19:0] M_RDST  = 20'h1 << 11;
  localparam logic [19:0] M_RW    = 20'h1 << 10;
  localparam logic [19:0] M_SRCA  = 20'h1 << 9;
  localparam logic [19:0] B_01    = 20'h1 << 7;
  localparam logic [19:0] B_10    = 20'h2 << 7;
  localparam logic [19:0] B_11    = 20'h3 << 7;
  localparam logic [19:0] M_ZEXT  = 20'h1 << 6;
  localparam logic [19:0] A_01    = 20'h1 << 4;
  localparam logic [19:0] A_10    = 20'h2 << 4;
  localparam logic [19:0] A_11    = 20'h3 << 4;
  localparam logic [19:0] P_01    = 20'h1 << 2;
  localparam logic [19:0] P_10    = 20'h2 << 2;
  localparam logic [19:0] M_ILL   = 20'h1 << 1;
  localparam logic [19:0] M_DONE  = 20'h1;

  localparam logic [19:0] E_ZERO     = 20'h0;
  localparam logic [19:0] E_FETCH_W  = M_MRD | B_01;
  localparam logic [19:0] E_FETCH_R  = M_MRD | B_01 | M_PCW | M_IRW;
  localparam logic [19:0] E_DECODE   = B_11;
  localparam logic [19:0] E_DEC_ILL  = B_11 | M_ILL;
  localparam logic [19:0] E_MEMADR   = M_SRCA | B_10;
  localparam logic [19:0] E_MEMRD    = M_MRD | M_IORD;
  localparam logic [19:0] E_MEMWR_W  = M_MWR | M_IORD;
  localparam logic [19:0] E_MEMWR_R  = M_MWR | M_IORD | M_DONE;
  localparam logic [19:0] E_MEMWB    = M_RW | M_M2R | M_DONE;
  localparam logic [19:0] E_EXEC     = M_SRCA | A_10;
  localparam logic [19:0] E_RWB      = M_RW | M_RDST | M_DONE;
  localparam logic [19:0] E_BRANCH   = M_SRCA | A_01 | M_PCWC | P_01 | M_DONE;
  localparam logic [19:0] E_BRANCH_NE = E_BRANCH | M_BNE;
  localparam logic [19:0] E_JUMP     = M_PCW | P_10 | M_DONE;
  localparam logic [19:0] E_IEXEC    = M_SRCA | B_10 | A_11;
  localparam logic [19:0] E_IEXEC_Z  = E_IEXEC | M_ZEXT;
  localparam logic [19:0] E_IWB      = M_RW | M_DONE;

  localparam logic [5:0] O_R   = 6'b000000;
  localparam logic [5:0] O_LW  = 6'b100011;
  localparam logic [5:0] O_SW  = 6'b101011;
  localparam logic [5:0] O_BEQ = 6'b000100;
  localparam logic [5:0] O_BNE = 6'b000101;
  localparam logic [5:0] O_J   = 6'b000010;
  localparam logic [5:0] O_ADDI = 6'b001000;
  localparam logic [5:0] O_ORI = 6'b001101;
  localparam logic [5:0] O_XORI = 6'b001110;
  localparam logic [5:0] O_BAD = 6'b111111;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        rdy;
    logic [19:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [19:0] exp;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_checks;
  int   n_errors;

  task automatic add(input logic r, input logic [5:0] o, input logic rd,
                     input logic [19:0] e, input string nm);
    vec_t v;
    v.rst_n = r; v.op = o; v.rdy = rd; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check_word(input string nm, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    sb_t e;
    int  waits, cycles, pcw, irw, m2r, done_seen;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    Op        = O_LW;
    mem_ready = 1'b1;

    add(1'b0, O_LW,  1'b1, E_ZERO,     "reset0");
    add(1'b0, O_LW,  1'b1, E_ZERO,     "reset1");
    // add: FETCH waits one cycle, then FETCH DECODE EXEC RWB
    add(1'b1, O_R,   1'b0, E_FETCH_W,  "add.fetch_wait");
    add(1'b1, O_R,   1'b1, E_FETCH_R,  "add.fetch");
    add(1'b1, O_R,   1'b1, E_DECODE,   "add.decode");
    add(1'b1, O_R,   1'b1, E_EXEC,     "add.exec");
    add(1'b1, O_R,   1'b1, E_RWB,      "add.rwb");
    // lw with two MEMRD wait cycles: 7-cycle instruction
    add(1'b1, O_LW,  1'b1, E_FETCH_R,  "lw.fetch");
    add(1'b1, O_LW,  1'b1, E_DECODE,   "lw.decode");
    add(1'b1, O_LW,  1'b1, E_MEMADR,   "lw.memadr");
    add(1'b1, O_LW,  1'b0, E_MEMRD,    "lw.memrd_w1");
    add(1'b1, O_LW,  1'b0, E_MEMRD,    "lw.memrd_w2");
    add(1'b1, O_LW,  1'b1, E_MEMRD,    "lw.memrd");
    add(1'b1, O_LW,  1'b1, E_MEMWB,    "lw.memwb");
    // ori: zero-extended I-type
    add(1'b1, O_ORI, 1'b1, E_FETCH_R,  "ori.fetch");
    add(1'b1, O_ORI, 1'b1, E_DECODE,   "ori.decode");
    add(1'b1, O_ORI, 1'b1, E_IEXEC_Z,  "ori.iexec");
    add(1'b1, O_ORI, 1'b1, E_IWB,      "ori.iwb");
    // addi: sign-extended I-type
    add(1'b1, O_ADDI, 1'b1, E_FETCH_R, "addi.fetch");
    add(1'b1, O_ADDI, 1'b1, E_DECODE,  "addi.decode");
    add(1'b1, O_ADDI, 1'b1, E_IEXEC,   "addi.iexec");
    add(1'b1, O_ADDI, 1'b1, E_IWB,     "addi.iwb");
    // illegal opcode: DECODE pulses illegal_op then back to FETCH
    add(1'b1, O_BAD, 1'b1, E_FETCH_R,  "bad.fetch");
    add(1'b1, O_BAD, 1'b1, E_DEC_ILL,  "bad.decode");
    add(1'b1, O_BAD, 1'b0, E_FETCH_W,  "bad.refetch");
    // beq: 3 cycles
    add(1'b1, O_BEQ, 1'b1, E_FETCH_R,  "beq.fetch");
    add(1'b1, O_BEQ, 1'b1, E_DECODE,   "beq.decode");
    add(1'b1, O_BEQ, 1'b1, E_BRANCH,   "beq.branch");
    // bne depends on build option
    add(1'b1, O_BNE, 1'b1, E_FETCH_R,  "bne.fetch");
`ifdef MC_CTRL_BNE_EN
    add(1'b1, O_BNE, 1'b1, E_DECODE,   "bne.decode");
    add(1'b1, O_BNE, 1'b0, E_BRANCH_NE, "bne.branch");
`else
    add(1'b1, O_BNE, 1'b1, E_DEC_ILL,  "bne.decode_ill");
    add(1'b1, O_BNE, 1'b0, E_FETCH_W,  "bne.refetch");
`endif
    // j: 3 cycles
    add(1'b1, O_J,   1'b1, E_FETCH_R,  "j.fetch");
    add(1'b1, O_J,   1'b1, E_DECODE,   "j.decode");
    add(1'b1, O_J,   1'b1, E_JUMP,     "j.jump");
    // sw aborted by reset during its memory wait
    add(1'b1, O_SW,  1'b1, E_FETCH_R,  "swr.fetch");
    add(1'b1, O_SW,  1'b1, E_DECODE,   "swr.decode");
    add(1'b1, O_SW,  1'b1, E_MEMADR,   "swr.memadr");
    add(1'b1, O_SW,  1'b0, E_MEMWR_W,  "swr.memwr_wait");
    add(1'b0, O_SW,  1'b0, E_ZERO,     "swr.reset");
    add(1'b1, O_SW,  1'b0, E_FETCH_W,  "swr.fetch_wait");
    // plain sw, 4 cycles
    add(1'b1, O_SW,  1'b1, E_FETCH_R,  "sw.fetch");
    add(1'b1, O_SW,  1'b1, E_DECODE,   "sw.decode");
    add(1'b1, O_SW,  1'b1, E_MEMADR,   "sw.memadr");
    add(1'b1, O_SW,  1'b1, E_MEMWR_R,  "sw.memwr");
    add(1'b1, O_SW,  1'b0, E_FETCH_W,  "sw.next_fetch");
    // xori then a reset mid-instruction
    add(1'b1, O_XORI, 1'b1, E_FETCH_R, "xori.fetch");
    add(1'b1, O_XORI, 1'b1, E_DECODE,  "xori.decode");
    add(1'b1, O_XORI, 1'b1, E_IEXEC_Z, "xori.iexec");
    add(1'b0, O_XORI, 1'b1, E_ZERO,    "xori.reset");
    add(1'b1, O_LW,  1'b0, E_FETCH_W,  "post_reset.fetch");

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n     = vecs[i].rst_n;
      Op        = vecs[i].op;
      mem_ready = vecs[i].rdy;
      e.exp  = vecs[i].exp;
      e.name = vecs[i].name;
      sb.push_back(e);
      #2;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        e = sb.pop_front();
        check_word(e.name, obs, e.exp);
      end
    end

    // lw with three MEMRD wait states, memory answers reactively: 8 cycles.
    Op        = O_LW;
    waits     = 0;
    cycles    = 0;
    pcw       = 0;
    irw       = 0;
    m2r       = 0;
    done_seen = 0;
    while (done_seen == 0 && cycles < 20) begin
      @(negedge clk);
      if (MemRead && IorD && waits < 3) begin
        mem_ready = 1'b0;
        waits++;
      end else begin
        mem_ready = 1'b1;
      end
      #2;
      cycles++;
      if (PCWrite) pcw++;
      if (IRWrite) irw++;
      if (instr_done) begin
        done_seen = 1;
        m2r = int'(MemtoReg);
      end
    end
    check_int("lw_wait.done_seen", done_seen, 1);
    check_int("lw_wait.latency", cycles, 8);
    check_int("lw_wait.pcwrite_pulses", pcw, 1);
    check_int("lw_wait.irwrite_pulses", irw, 1);
    check_int("lw_wait.memtoreg", m2r, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
